// File: rtl/instruction_fetch_controller.sv
// Owns the PC and registers each fetched word for decode. First word valid two edges after start, and two edges after a redirect.
// A word waits in the output register while decode stalls. Fetch and accept in the same cycle give one word per cycle.
module instruction_fetch_controller #(
  parameter int                ADDR_W     = 18,
  parameter int                DATA_W     = 18,
  parameter logic [ADDR_W-1:0] START_ADDR = 18'h00000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 18'h3FFFF,
  parameter logic [DATA_W-1:0] HALT_WORD  = 18'h3FFFF,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetchStateE;

  // Range check is done as an unsigned offset compare one bit wider than the
  // address, so it stays correct when START_ADDR is 0 or END_ADDR is all-ones.
  localparam logic [ADDR_W:0] ADDR_SPAN = {1'b0, END_ADDR - START_ADDR};

  fetchStateE        state;
  fetchStateE        nextState;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   redirOffset;
  logic              redirInRange;
  logic              load;
  logic              isHalt;

  assign imem_addr    = pc;
  assign busy         = (state == FETCH);
  assign halted       = (state == HALTED);
  assign isHalt       = (imem_data == HALT_WORD);
  assign load         = (state == FETCH) && (!inst_valid || inst_ready) && !redirect_valid;
  assign redirOffset  = {1'b0, redirect_addr - START_ADDR};
  assign redirInRange = (redirOffset <= ADDR_SPAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        if (load && isHalt) nextState = HALTED;
      end
      HALTED: begin
        if (start || redirect_valid) nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= START_ADDR;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc         <= redirInRange ? redirect_addr : START_ADDR;
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_data  <= imem_data;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
      pc         <= (pc == END_ADDR) ? START_ADDR : pc + ADDR_W'(1);
      if (fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
    end else if (inst_ready) begin
      // Only reachable outside FETCH: drain the last word after a halt or stop.
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench: one default-parameter fetch unit plus a second one with END_ADDR=7 for wrap checks.
module tb_instruction_fetch_controller;

  localparam logic [17:0] HALT = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] mem [0:511];

  logic        start = 1'b0, instReady = 1'b0, redirectValid = 1'b0;
  logic [17:0] redirectAddr = '0;
  logic [17:0] imemAddr, imemData, instData, instPc;
  logic        instValid, busy, halted;
  logic [15:0] fetchCount;

  logic        start7 = 1'b0, instReady7 = 1'b0, redirectValid7 = 1'b0;
  logic [17:0] redirectAddr7 = '0;
  logic [17:0] imemAddr7, imemData7, instData7, instPc7;
  logic        instValid7, busy7, halted7;
  logic [15:0] fetchCount7;

  always #5 clk = ~clk;

  assign imemData  = mem[imemAddr[8:0]];
  assign imemData7 = mem[imemAddr7[8:0]];

  instruction_fetch_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imemAddr), .imem_data(imemData),
    .inst_valid(instValid), .inst_ready(instReady),
    .inst_data(instData), .inst_pc(instPc),
    .redirect_valid(redirectValid), .redirect_addr(redirectAddr),
    .busy(busy), .halted(halted), .fetch_count(fetchCount)
  );

  instruction_fetch_controller #(.END_ADDR(18'h7)) dut7 (
    .clk(clk), .rst(rst), .start(start7),
    .imem_addr(imemAddr7), .imem_data(imemData7),
    .inst_valid(instValid7), .inst_ready(instReady7),
    .inst_data(instData7), .inst_pc(instPc7),
    .redirect_valid(redirectValid7), .redirect_addr(redirectAddr7),
    .busy(busy7), .halted(halted7), .fetch_count(fetchCount7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    start = 0; instReady = 0; redirectValid = 0; redirectAddr = '0;
    start7 = 0; instReady7 = 0; redirectValid7 = 0; redirectAddr7 = '0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    doReset();
    tick();
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL reset inst_valid got %b exp 0", instValid); end
    checks++; if (instData !== 18'd0) begin errors++; $display("FAIL reset inst_data got %h exp 0", instData); end
    checks++; if (instPc !== 18'd0) begin errors++; $display("FAIL reset inst_pc got %h exp 0", instPc); end
    checks++; if (imemAddr !== 18'd0) begin errors++; $display("FAIL reset imem_addr got %h exp 0", imemAddr); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset busy/halted got %b/%b exp 0/0", busy, halted); end
    checks++; if (fetchCount !== 16'd0) begin errors++; $display("FAIL reset fetch_count got %0d exp 0", fetchCount); end
  endtask

  task automatic test_sequential();
    doReset();
    instReady = 1; start = 1;
    tick();
    start = 0;
    checks++; if (busy !== 1'b1 || instValid !== 1'b0) begin errors++; $display("FAIL seq start busy/valid got %b/%b exp 1/0", busy, instValid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instValid !== 1'b1 || instData !== 18'(i + 1) || instPc !== 18'(i))
        begin errors++; $display("FAIL seq word%0d valid/data/pc got %b/%h/%h exp 1/%h/%h", i, instValid, instData, instPc, i + 1, i); end
      checks++; if (fetchCount !== 16'(i + 1)) begin errors++; $display("FAIL seq count%0d got %0d exp %0d", i, fetchCount, i + 1); end
    end
  endtask

  task automatic test_stall();
    doReset();
    instReady = 1; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    instReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instValid !== 1'b1 || instData !== 18'd2 || instPc !== 18'd1 || imemAddr !== 18'd2 || fetchCount !== 16'd2)
        begin errors++; $display("FAIL stall hold%0d valid/data/pc/addr/count got %b/%h/%h/%h/%0d exp 1/2/1/2/2", i, instValid, instData, instPc, imemAddr, fetchCount); end
    end
    instReady = 1;
    tick();
    checks++; if (instData !== 18'd3 || instPc !== 18'd2 || fetchCount !== 16'd3)
      begin errors++; $display("FAIL stall release data/pc/count got %h/%h/%0d exp 3/2/3", instData, instPc, fetchCount); end
    tick();
    checks++; if (instData !== 18'd4 || instPc !== 18'd3) begin errors++; $display("FAIL stall next data/pc got %h/%h exp 4/3", instData, instPc); end
  endtask

  task automatic test_redirect();
    doReset();
    instReady = 1; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    checks++; if (instPc !== 18'd2) begin errors++; $display("FAIL redir setup inst_pc got %h exp 2", instPc); end
    redirectValid = 1; redirectAddr = 18'h100;
    tick();
    redirectValid = 0;
    checks++; if (instValid !== 1'b0 || imemAddr !== 18'h100 || fetchCount !== 16'd3)
      begin errors++; $display("FAIL redir flush valid/addr/count got %b/%h/%0d exp 0/100/3", instValid, imemAddr, fetchCount); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 18'h100 || instData !== 18'h101)
      begin errors++; $display("FAIL redir target valid/pc/data got %b/%h/%h exp 1/100/101", instValid, instPc, instData); end
    instReady = 0;
    tick();
    redirectValid = 1; redirectAddr = 18'h20;
    tick();
    redirectValid = 0;
    checks++; if (instValid !== 1'b0 || imemAddr !== 18'h20)
      begin errors++; $display("FAIL redir stalled flush valid/addr got %b/%h exp 0/20", instValid, imemAddr); end
    instReady = 1;
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 18'h20 || instData !== 18'h21 || fetchCount !== 16'd5)
      begin errors++; $display("FAIL redir stalled target valid/pc/data/count got %b/%h/%h/%0d exp 1/20/21/5", instValid, instPc, instData, fetchCount); end
  endtask

  task automatic test_halt();
    mem[5] = HALT;
    doReset();
    instReady = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (instValid !== 1'b1 || instData !== HALT || instPc !== 18'd5)
      begin errors++; $display("FAIL halt word valid/data/pc got %b/%h/%h exp 1/%h/5", instValid, instData, instPc, HALT); end
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || imemAddr !== 18'd6 || fetchCount !== 16'd6)
      begin errors++; $display("FAIL halt state halted/busy/addr/count got %b/%b/%h/%0d exp 1/0/6/6", halted, busy, imemAddr, fetchCount); end
    tick(); tick();
    checks++; if (instValid !== 1'b0 || imemAddr !== 18'd6 || fetchCount !== 16'd6 || halted !== 1'b1)
      begin errors++; $display("FAIL halt idle valid/addr/count/halted got %b/%h/%0d/%b exp 0/6/6/1", instValid, imemAddr, fetchCount, halted); end
    start = 1;
    tick();
    start = 0;
    checks++; if (busy !== 1'b1 || instValid !== 1'b0) begin errors++; $display("FAIL halt resume busy/valid got %b/%b exp 1/0", busy, instValid); end
    tick();
    checks++; if (instValid !== 1'b1 || instPc !== 18'd6 || instData !== 18'd7 || fetchCount !== 16'd7)
      begin errors++; $display("FAIL halt resume word valid/pc/data/count got %b/%h/%h/%0d exp 1/6/7/7", instValid, instPc, instData, fetchCount); end
    mem[5] = 18'd6;
  endtask

  task automatic test_wrap();
    doReset();
    instReady7 = 1; start7 = 1;
    tick();
    start7 = 0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (instPc7 !== 18'd7 || instData7 !== 18'd8) begin errors++; $display("FAIL wrap last pc/data got %h/%h exp 7/8", instPc7, instData7); end
    tick();
    checks++; if (instValid7 !== 1'b1 || instPc7 !== 18'd0 || instData7 !== 18'd1)
      begin errors++; $display("FAIL wrap first valid/pc/data got %b/%h/%h exp 1/0/1", instValid7, instPc7, instData7); end
    redirectValid7 = 1; redirectAddr7 = 18'd9;
    tick();
    redirectValid7 = 0;
    checks++; if (instValid7 !== 1'b0 || imemAddr7 !== 18'd0 || fetchCount7 !== 16'd9)
      begin errors++; $display("FAIL wrap redirect valid/addr/count got %b/%h/%0d exp 0/0/9", instValid7, imemAddr7, fetchCount7); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    instReady = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    instReady = 0;
    tick();
    checks++; if (instValid !== 1'b1 || instData !== 18'd2) begin errors++; $display("FAIL rststall setup valid/data got %b/%h exp 1/2", instValid, instData); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (instValid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imemAddr !== 18'd0 || fetchCount !== 16'd0)
      begin errors++; $display("FAIL rststall valid/busy/halted/addr/count got %b/%b/%b/%h/%0d exp 0/0/0/0/0", instValid, busy, halted, imemAddr, fetchCount); end
    checks++; if (instData !== 18'd0 || instPc !== 18'd0) begin errors++; $display("FAIL rststall data/pc got %h/%h exp 0/0", instData, instPc); end
    tick();
    checks++; if (busy !== 1'b0 || instValid !== 1'b0) begin errors++; $display("FAIL rststall idle busy/valid got %b/%b exp 0/0", busy, instValid); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 18'(i + 1);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
